ov7670_config_seq: RTL
======================

// Module: ov7670_config_seq
// PURPOSE
//   Camera register-init sequencer, directly upstream of the SCCB sender.
//   Walks an internal table of {register,value} pairs and presents each one
//   to the sender on id/register/value, holding send high until taken.
//   Supports a timed-delay entry and an end marker, and flags completion.
//   Can be restarted to rewrite the whole table.
// PARAMETERS
//   CAM_ID        8'h42      SCCB write address driven on id
//   DELAY_CYCLES  1_000_000  clk cycles waited on a delay entry (>=1)
//   ROM_DEPTH     64         table entries; address width = clog2(ROM_DEPTH)
// PORTS
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   taken        in   1  sender strobe: entry latched this cycle (1-cycle pulse)
//   resend       in   1  restart the table from entry 0 (honoured only in DONE)
//   send         out  1  request to sender; held until taken
//   id           out  8  constant CAM_ID
//   register     out  8  register address of the current entry
//   value        out  8  data byte of the current entry
//   config_done  out  1  high while in DONE
// BEHAVIOUR
// - Reset (async assert, sync release): send=0, register=0, value=0,
//   config_done=0, id=CAM_ID, addr=0, delay count=0, state=FETCH.
// - Table: synchronous case-ROM of 16-bit {reg,val}; read data valid 1 cycle
//   after addr changes.
// - Table contents:
//   - Entry 0 = 16'h1280 (COM7 soft reset).
//   - Entry 1 = 16'hF0F0 (delay).
//   - Entry 2 = 16'h1204 (RGB).
//   - Entry 3 = 16'h40D0 (RGB565).
//   - Then the remaining camera settings.
//   - Terminated by 16'hFFFF.
//   - Unused entries = 16'hFFFF.
// - FETCH: one wait cycle for ROM data, then decode:
//   - 16'hFFFF -> DONE.
//   - 16'hF0F0 -> DELAY, load counter.
//   - Any other value -> SEND, register/value <= entry, send <= 1.
// - SEND: send held at 1; register/value are stable.
//   - On taken: send <= 0 on the same edge, addr <= addr+1, -> FETCH.
//   - The next send is therefore raised at least 2 cycles after taken.
//     The sender ignores it until its own frame completes.
// - DELAY: send=0. Counter runs DELAY_CYCLES cycles, then addr+1, -> FETCH.
// - DONE:
//   - On entry: config_done=1, send=0.
//   - resend=1 -> addr=0, config_done <= 0, -> FETCH.
// - resend outside DONE is ignored (no queuing).
// - Address wrap: if addr==ROM_DEPTH-1 and the entry is not the end marker,
//   send it, then go to DONE instead of wrapping to 0.
// - taken while not in SEND: ignored. taken and resend on the same cycle in
//   DONE: resend wins.
// - Reset mid-transaction: all outputs return to reset values immediately.
//   The table restarts from entry 0 after release.
// - Sender power-up pause: no special handling; send is simply held until
//   taken.
// TESTING
// 1. Release reset, taken never pulsed -> send=1, register=8'h12,
//    value=8'h80, id=8'h42 within 3 cycles, held stable for 1000 cycles.
// 2. Pulse taken 1 cycle -> send=0 next cycle.
//    With DELAY_CYCLES=16: send stays 0 for >=16 cycles.
//    Then send=1 with register=8'h12, value=8'h04.
// 3. Bench model answers every request with taken 300 cycles after send
//    rises -> logged pairs match the table in order.
//    config_done=1 after the 16'hFFFF entry; send stays 0 thereafter.
// 4. resend pulse while busy (mid-table) -> no effect on the sequence.
//    resend in DONE -> config_done=0 next cycle; entry 0 (12/80) re-sent.
// 5. Assert rst_n=0 while send=1 mid-table (async, between edges) ->
//    send=0, config_done=0 immediately.
//    After release, the sequence restarts at 12/80.
// 6. Table with no end marker and ROM_DEPTH=4 -> exactly 4 entries
//    processed, then config_done=1; addr does not wrap.

Source files
------------

// File: rtl/ov7670_config_seq_if.sv
// Request/accept link between the init sequencer and the SCCB sender.
// The sequencer presents one {id, register, value} write and holds send until taken.
interface ov7670_config_seq_if;
  logic       send;
  logic       taken;
  logic [7:0] id;
  logic [7:0] register;
  logic [7:0] value;

  modport master (output send, output id, output register, output value, input taken);
  modport slave  (input send, input id, input register, input value, output taken);
endinterface

// File: rtl/ov7670_config_seq.sv
// OV7670 register-init sequencer: walks a {register,value} table, inserts timed
// delays, hands each write to the SCCB sender and flags completion.
module ov7670_config_seq #(
  parameter logic [7:0]  CAM_ID       = 8'h42,
  parameter int unsigned DELAY_CYCLES = 1_000_000,
  parameter int unsigned ROM_DEPTH    = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        resend,
  output logic                        config_done,
  ov7670_config_seq_if.master         sccb
);

  localparam int unsigned AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int unsigned CW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [AW-1:0] LAST_ADDR  = AW'(ROM_DEPTH - 1);
  localparam logic [CW-1:0] DELAY_LOAD = CW'(DELAY_CYCLES - 1);
  localparam logic [15:0]   END_MARK   = 16'hFFFF;
  localparam logic [15:0]   DELAY_MARK = 16'hF0F0;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_SEND, S_DELAY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   rom_q;
  logic          send_d, done_d, adv;
  logic [7:0]    reg_d, val_d;

  // Init table: soft reset, settle delay, RGB565 output, then image tuning.
  function automatic logic [15:0] rom_entry(input int unsigned idx);
    case (idx)
      0:       rom_entry = 16'h1280;
      1:       rom_entry = 16'hF0F0;
      2:       rom_entry = 16'h1204;
      3:       rom_entry = 16'h40D0;
      4:       rom_entry = 16'h1100;
      5:       rom_entry = 16'h0C00;
      6:       rom_entry = 16'h3E00;
      7:       rom_entry = 16'h8C00;
      8:       rom_entry = 16'h0400;
      9:       rom_entry = 16'h3A04;
      10:      rom_entry = 16'h1438;
      11:      rom_entry = 16'h4FB3;
      12:      rom_entry = 16'h50B3;
      13:      rom_entry = 16'h5100;
      14:      rom_entry = 16'h523D;
      15:      rom_entry = 16'h53A7;
      16:      rom_entry = 16'h54E4;
      17:      rom_entry = 16'h589E;
      18:      rom_entry = 16'h3DC0;
      19:      rom_entry = 16'h1714;
      20:      rom_entry = 16'h1802;
      21:      rom_entry = 16'h3280;
      22:      rom_entry = 16'h1903;
      23:      rom_entry = 16'h1A7B;
      24:      rom_entry = 16'h030A;
      25:      rom_entry = 16'h0F41;
      26:      rom_entry = 16'h1E00;
      27:      rom_entry = 16'h330B;
      28:      rom_entry = 16'h3C78;
      29:      rom_entry = 16'h6900;
      30:      rom_entry = 16'h7400;
      31:      rom_entry = 16'hB084;
      default: rom_entry = END_MARK;
    endcase
  endfunction

  // Synchronous table read: data follows addr by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rom_q <= END_MARK;
    else        rom_q <= rom_entry(32'(addr_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      addr_q        <= '0;
      cnt_q         <= '0;
      sccb.send     <= 1'b0;
      sccb.id       <= CAM_ID;
      sccb.register <= 8'h00;
      sccb.value    <= 8'h00;
      config_done   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      sccb.send     <= send_d;
      sccb.id       <= CAM_ID;
      sccb.register <= reg_d;
      sccb.value    <= val_d;
      config_done   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    send_d  = sccb.send;
    reg_d   = sccb.register;
    val_d   = sccb.value;
    done_d  = config_done;
    adv     = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (rom_q == END_MARK) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          send_d  = 1'b0;
        end else if (rom_q == DELAY_MARK) begin
          state_d = S_DELAY;
          cnt_d   = DELAY_LOAD;
        end else begin
          state_d = S_SEND;
          send_d  = 1'b1;
          reg_d   = rom_q[15:8];
          val_d   = rom_q[7:0];
        end
      end
      S_SEND: begin
        if (sccb.taken) begin
          send_d = 1'b0;
          adv    = 1'b1;
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) adv = 1'b1;
        else             cnt_d = cnt_q - CW'(1);
      end
      S_DONE: begin
        if (resend) begin
          addr_d  = '0;
          done_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
    // The last table slot finishes the run instead of wrapping to entry 0.
    if (adv) begin
      if (addr_q == LAST_ADDR) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        addr_d  = addr_q + AW'(1);
        state_d = S_FETCH;
      end
    end
  end

endmodule
